// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 2;

    // Bit-counter width; never narrower than one bit so WIDTH=1 still has a counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the single shared arithmetic cell of the serial datapath.
module full_adder (
    input  logic in1,
    input  logic in2,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = in1 ^ in2 ^ carry_in;
    assign carry_out = (in1 & in2) | (in1 & carry_in) | (in2 & carry_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder reused per bit, one bit per clock, registered result.
// Optional macro SERIAL_ADD_SUB_EN adds i_sub for two's-complement subtraction (A - B).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH:0]   o_sum
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, a_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [WIDTH-1:0] r_r, r_s;
    logic             carry_r, carry_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH:0]   sum_r, sum_s;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic             sub_s;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_s = i_sub;
`else
    assign sub_s = 1'b0;
`endif

    full_adder u_fa (
        .in1       (a_r[0]),
        .in2       (b_r[0]),
        .carry_in  (carry_r),
        .sum       (fa_sum_s),
        .carry_out (fa_cout_s)
    );

    // Next-state and datapath update; every register holds unless a state acts on it.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        r_s     = r_r;
        carry_s = carry_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        sum_s   = sum_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    a_s     = i_op_a;
                    b_s     = sub_s ? ~i_op_b : i_op_b;
                    carry_s = sub_s;
                    cnt_s   = {CW{1'b0}};
                    busy_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_s            = a_r >> 1;
                b_s            = b_r >> 1;
                r_s            = r_r >> 1;
                r_s[WIDTH-1]   = fa_sum_s;
                carry_s        = fa_cout_s;
                cnt_s          = cnt_r + CW'(1);
                // Result is loaded on the final bit so it is valid alongside the done pulse.
                if (cnt_r == CW'(WIDTH - 1)) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    sum_s   = {fa_cout_s, r_s};
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            r_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= {(WIDTH+1){1'b0}};
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            r_r     <= r_s;
            carry_r <= carry_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            sum_r   <= sum_s;
        end
    end

    assign o_busy = busy_r;
    assign o_done = done_r;
    assign o_sum  = sum_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, table-driven bench for serial_add_ctrl at WIDTH=2 and WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start2, busy2, done2;
    logic [1:0] op_a2, op_b2;
    logic [2:0] sum2;
    logic       sub2;
    logic       start8, busy8, done8;
    logic [7:0] op_a8, op_b8;
    logic [8:0] sum8;

    int total;
    int bad;
    int npulse;

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start2),
        .i_op_a  (op_a2),
        .i_op_b  (op_b2),
`ifdef SERIAL_ADD_SUB_EN
        .i_sub   (sub2),
`endif
        .o_busy  (busy2),
        .o_done  (done2),
        .o_sum   (sum2)
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start8),
        .i_op_a  (op_a8),
        .i_op_b  (op_b8),
`ifdef SERIAL_ADD_SUB_EN
        .i_sub   (1'b0),
`endif
        .o_busy  (busy8),
        .o_done  (done8),
        .o_sum   (sum8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] s;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single WIDTH=2 operation from IDLE with full latency profile.
    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic sub, input logic [2:0] exp);
        op_a2  = a;
        op_b2  = b;
        sub2   = sub;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk("busy2", {31'd0, busy2}, {31'd0, (k <= 2)});
            chk("done2", {31'd0, done2}, {31'd0, (k == 3)});
            if (k == 3) chk("sum2", {29'd0, sum2}, {29'd0, exp});
            else tick();
        end
        tick();
        chk("done2_clear", {31'd0, done2}, 32'd0);
        chk("sum2_hold", {29'd0, sum2}, {29'd0, exp});
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        op_a8  = a;
        op_b8  = b;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk("busy8", {31'd0, busy8}, {31'd0, (k <= 8)});
            chk("done8", {31'd0, done8}, {31'd0, (k == 9)});
            if (k == 9) chk("sum8", {23'd0, sum8}, {23'd0, exp});
            else tick();
        end
        tick();
        chk("done8_clear", {31'd0, done8}, 32'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start2 = 1'b0;
        op_a2  = 2'd0;
        op_b2  = 2'd0;
        sub2   = 1'b0;
        start8 = 1'b0;
        op_a8  = 8'd0;
        op_b8  = 8'd0;

        tbl[0] = '{a: 2'd3, b: 2'd3, s: 3'b110};
        tbl[1] = '{a: 2'd1, b: 2'd2, s: 3'b011};
        tbl[2] = '{a: 2'd0, b: 2'd0, s: 3'b000};
        tbl[3] = '{a: 2'd2, b: 2'd3, s: 3'b101};
        tbl[4] = '{a: 2'd3, b: 2'd0, s: 3'b011};
        tbl[5] = '{a: 2'd1, b: 2'd1, s: 3'b010};
        tbl[6] = '{a: 2'd2, b: 2'd2, s: 3'b100};

        repeat (2) tick();
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        chk("rst_done2", {31'd0, done2}, 32'd0);
        chk("rst_sum2", {29'd0, sum2}, 32'd0);
        chk("rst_sum8", {23'd0, sum8}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run2(tbl[i].a, tbl[i].b, 1'b0, tbl[i].s);

        // Back-to-back with start held high: pulses at cycles 3 and 7.
        op_a2  = 2'd1;
        op_b2  = 2'd2;
        start2 = 1'b1;
        tick();
        op_a2  = 2'd0;
        op_b2  = 2'd0;
        npulse = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done2) begin
                npulse++;
                if (npulse == 1) begin
                    chk("b2b_t1", c, 32'd3);
                    chk("b2b_s1", {29'd0, sum2}, 32'd3);
                end else begin
                    chk("b2b_t2", c, 32'd7);
                    chk("b2b_s2", {29'd0, sum2}, 32'd0);
                end
            end
            if (c == 5) start2 = 1'b0;
            tick();
        end
        chk("b2b_count", npulse, 32'd2);

        // Start pulsed and operands changed during RUN: ignored.
        op_a2  = 2'd3;
        op_b2  = 2'd1;
        start2 = 1'b1;
        tick();
        op_a2  = 2'd0;
        op_b2  = 2'd0;
        npulse = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) start2 = 1'b0;
            if (done2) begin
                npulse++;
                chk("ign_t", c, 32'd3);
                chk("ign_s", {29'd0, sum2}, 32'd4);
            end
            tick();
        end
        chk("ign_count", npulse, 32'd1);
        chk("ign_hold", {29'd0, sum2}, 32'd4);

        // Reset in the first RUN cycle abandons the operation.
        op_a2  = 2'd3;
        op_b2  = 2'd3;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("mid_busy_pre", {31'd0, busy2}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy2}, 32'd0);
        chk("mid_done", {31'd0, done2}, 32'd0);
        chk("mid_sum", {29'd0, sum2}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        npulse = 0;
        for (int c = 1; c <= 6; c++) begin
            if (done2) npulse++;
            tick();
        end
        chk("mid_nopulse", npulse, 32'd0);
        run2(2'd1, 2'd1, 1'b0, 3'b010);

`ifdef SERIAL_ADD_SUB_EN
        run2(2'd2, 2'd3, 1'b1, 3'b011);
        run2(2'd3, 2'd1, 1'b1, 3'b110);
        run2(2'd3, 2'd1, 1'b0, 3'b100);
`endif

        run8(8'hFF, 8'h01, 9'h100);
        run8(8'hFF, 8'hFF, 9'h1FE);
        run8(8'hA5, 8'h5A, 9'h0FF);
        run8(8'h00, 8'h00, 9'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
